// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control unit: registered state, combinational control decode.
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        mem_wr,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        ext_op,
  output logic [2:0]  state,
  output logic        halt,
  output logic        retire,
  output logic [31:0] instr_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

  logic ir_wr_c, pc_wr_c, reg_wr_c, mem_wr_c, alu_src_b_c, ext_op_c, halt_c, retire_c;
  logic [1:0] pc_src_c, reg_dst_c, wd_sel_c;
  logic [2:0] alu_op_c;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_rtype, is_legal;

  // Instruction class decode from opcode/funct
  always_comb begin
    is_addu  = (op == 6'h00) && (funct == 6'h21);
    is_subu  = (op == 6'h00) && (funct == 6'h23);
    is_jr    = (op == 6'h00) && (funct == 6'h08);
    is_ori   = (op == 6'h0D);
    is_lui   = (op == 6'h0F);
    is_lw    = (op == 6'h23);
    is_sw    = (op == 6'h2B);
    is_beq   = (op == 6'h04);
    is_j     = (op == 6'h02);
    is_jal   = (op == 6'h03);
    is_rtype = is_addu | is_subu;
    is_legal = is_rtype | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_d     = state_q;
    ir_wr_c     = 1'b0;
    pc_wr_c     = 1'b0;
    pc_src_c    = 2'd0;
    reg_wr_c    = 1'b0;
    reg_dst_c   = 2'd0;
    wd_sel_c    = 2'd0;
    mem_wr_c    = 1'b0;
    alu_op_c    = 3'd0;
    alu_src_b_c = 1'b0;
    ext_op_c    = 1'b0;
    halt_c      = 1'b0;
    retire_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_wr_c  = 1'b1;
          pc_src_c = 2'd2;
          retire_c = 1'b1;
          state_d  = S_FETCH;
          if (is_jal) begin
            // PC already holds PC+4, so the link value is the current PC
            reg_wr_c  = 1'b1;
            reg_dst_c = 2'd2;
            wd_sel_c  = 2'd2;
          end
        end else if (is_jr) begin
          pc_wr_c  = 1'b1;
          pc_src_c = 2'd3;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_legal) begin
          state_d = S_EXEC;
        end else if (ILLEGAL_TRAP) begin
          state_d = S_HALT;
        end else begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_subu) begin
          alu_op_c = 3'd1;
        end else if (is_ori || is_lui) begin
          alu_op_c    = is_ori ? 3'd2 : 3'd3;
          alu_src_b_c = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src_b_c = 1'b1;
          ext_op_c    = 1'b1;
        end else if (is_beq) begin
          alu_op_c = 3'd1;
          ext_op_c = 1'b1;
        end
        if (is_beq) begin
          pc_wr_c  = zero;
          pc_src_c = 2'd1;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_rtype || is_ori || is_lui) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_wr_c = 1'b1;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_wr_c  = 1'b1;
        retire_c  = 1'b1;
        reg_dst_c = is_rtype ? 2'd1 : 2'd0;
        wd_sel_c  = is_lw ? 2'd1 : 2'd0;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halt_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (retire_c) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Outputs held low while reset is asserted, so an aborted instruction writes nothing
  assign ir_wr     = reset & ir_wr_c;
  assign pc_wr     = reset & pc_wr_c;
  assign pc_src    = reset ? pc_src_c : 2'd0;
  assign reg_wr    = reset & reg_wr_c;
  assign reg_dst   = reset ? reg_dst_c : 2'd0;
  assign wd_sel    = reset ? wd_sel_c : 2'd0;
  assign mem_wr    = reset & mem_wr_c;
  assign alu_op    = reset ? alu_op_c : 3'd0;
  assign alu_src_b = reset & alu_src_b_c;
  assign ext_op    = reset & ext_op_c;
  assign halt      = reset & halt_c;
  assign retire    = reset & retire_c;
  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; a second instance exercises the illegal-opcode trap.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  logic        ir_wr, pc_wr, reg_wr, mem_wr, alu_src_b, ext_op, halt, retire;
  logic [1:0]  pc_src, reg_dst, wd_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;

  logic        t_ir_wr, t_pc_wr, t_reg_wr, t_mem_wr, t_alu_src_b, t_ext_op, t_halt, t_retire;
  logic [1:0]  t_pc_src, t_reg_dst, t_wd_sel;
  logic [2:0]  t_alu_op, t_state;
  logic [31:0] t_instr_cnt;

  int checks = 0;
  int errors = 0;

  mc_controller #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .mem_wr(mem_wr), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .state(state), .halt(halt),
    .retire(retire), .instr_cnt(instr_cnt)
  );

  mc_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .ir_wr(t_ir_wr), .pc_wr(t_pc_wr), .pc_src(t_pc_src), .reg_wr(t_reg_wr),
    .reg_dst(t_reg_dst), .wd_sel(t_wd_sel), .mem_wr(t_mem_wr), .alu_op(t_alu_op),
    .alu_src_b(t_alu_src_b), .ext_op(t_ext_op), .state(t_state), .halt(t_halt),
    .retire(t_retire), .instr_cnt(t_instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample between edges
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    op    = 6'h00;
    funct = 6'h21;
    zero  = 1'b0;

    // Reset held: FETCH state but every control output forced low
    @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_ir_wr", 32'(ir_wr), 32'd0);
    chk("rst_pc_wr", 32'(pc_wr), 32'd0);
    chk("rst_trap_state", 32'(t_state), 32'd0);

    // addu: states 0,1,2,4
    reset = 1'b1; #1;
    chk("addu_f_state", 32'(state), 32'd0);
    chk("addu_f_irwr", 32'(ir_wr), 32'd1);
    chk("addu_f_pcwr", 32'(pc_wr), 32'd1);
    chk("addu_f_regwr", 32'(reg_wr), 32'd0);
    step();
    chk("addu_d_state", 32'(state), 32'd1);
    chk("addu_d_regwr", 32'(reg_wr), 32'd0);
    step();
    chk("addu_e_state", 32'(state), 32'd2);
    chk("addu_e_alu", {28'd0, alu_op, alu_src_b}, {28'd0, 3'd0, 1'b0});
    chk("addu_e_regwr", 32'(reg_wr), 32'd0);
    step();
    chk("addu_w_state", 32'(state), 32'd4);
    chk("addu_w_ctl", {27'd0, reg_wr, reg_dst, retire, 1'b0}, {27'd0, 1'b1, 2'd1, 1'b1, 1'b0});
    step();
    chk("addu_cnt", instr_cnt, 32'd1);
    chk("addu_next_state", 32'(state), 32'd0);

    // lw: 5 cycles, memory data in WB
    op = 6'h23; step();
    chk("lw_d_state", 32'(state), 32'd1);
    step();
    chk("lw_e_alu", {27'd0, alu_op, alu_src_b, ext_op}, {27'd0, 3'd0, 1'b1, 1'b1});
    step();
    chk("lw_m_state", 32'(state), 32'd3);
    chk("lw_m_memwr", 32'(mem_wr), 32'd0);
    chk("lw_m_retire", 32'(retire), 32'd0);
    step();
    chk("lw_w_state", 32'(state), 32'd4);
    chk("lw_w_ctl", {27'd0, reg_wr, reg_dst, wd_sel}, {27'd0, 1'b1, 2'd0, 2'd1});
    step();
    chk("lw_cnt", instr_cnt, 32'd2);

    // sw: mem_wr only in MEM
    op = 6'h2B;
    chk("sw_f_memwr", 32'(mem_wr), 32'd0);
    step();
    chk("sw_d_memwr", 32'(mem_wr), 32'd0);
    step();
    chk("sw_e_memwr", 32'(mem_wr), 32'd0);
    step();
    chk("sw_m_state", 32'(state), 32'd3);
    chk("sw_m_ctl", {30'd0, mem_wr, retire}, {30'd0, 1'b1, 1'b1});
    step();
    chk("sw_next_state", 32'(state), 32'd0);
    chk("sw_next_memwr", 32'(mem_wr), 32'd0);
    chk("sw_cnt", instr_cnt, 32'd3);

    // beq taken
    op = 6'h04; zero = 1'b1; step(); step();
    chk("beq1_e_state", 32'(state), 32'd2);
    chk("beq1_e_ctl", {26'd0, pc_wr, pc_src, alu_op}, {26'd0, 1'b1, 2'd1, 3'd1});
    chk("beq1_e_ext", {30'd0, alu_src_b, ext_op}, {30'd0, 1'b0, 1'b1});
    chk("beq1_retire", 32'(retire), 32'd1);
    step();
    chk("beq1_next_state", 32'(state), 32'd0);
    chk("beq1_cnt", instr_cnt, 32'd4);

    // beq not taken
    zero = 1'b0; step(); step();
    chk("beq0_e_pcwr", 32'(pc_wr), 32'd0);
    chk("beq0_retire", 32'(retire), 32'd1);
    step();
    chk("beq0_next_state", 32'(state), 32'd0);
    chk("beq0_cnt", instr_cnt, 32'd5);

    // jal: done in DECODE
    op = 6'h03; step();
    chk("jal_d_state", 32'(state), 32'd1);
    chk("jal_d_ctl", {24'd0, pc_wr, pc_src, reg_wr, reg_dst, wd_sel},
        {24'd0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
    chk("jal_d_retire", 32'(retire), 32'd1);
    step();
    chk("jal_next_state", 32'(state), 32'd0);
    chk("jal_cnt", instr_cnt, 32'd6);

    // ori: zero-extended imm, rt destination
    op = 6'h0D; step(); step();
    chk("ori_e_alu", {27'd0, alu_op, alu_src_b, ext_op}, {27'd0, 3'd2, 1'b1, 1'b0});
    step();
    chk("ori_w_ctl", {27'd0, reg_wr, reg_dst, wd_sel}, {27'd0, 1'b1, 2'd0, 2'd0});
    step();
    chk("ori_cnt", instr_cnt, 32'd7);

    // jr: register target
    op = 6'h00; funct = 6'h08; step();
    chk("jr_d_ctl", {28'd0, pc_wr, pc_src, reg_wr}, {28'd0, 1'b1, 2'd3, 1'b0});
    step();
    chk("jr_cnt", instr_cnt, 32'd8);

    // Illegal opcode: NOP on main instance, HALT on trap instance
    op = 6'h3F; step();
    chk("ill_d_retire", 32'(retire), 32'd1);
    chk("ill_d_trap_retire", 32'(t_retire), 32'd0);
    step();
    chk("ill_state", 32'(state), 32'd0);
    chk("ill_cnt", instr_cnt, 32'd9);
    chk("ill_trap_state", 32'(t_state), 32'd5);
    chk("ill_trap_halt", 32'(t_halt), 32'd1);
    chk("ill_trap_cnt", t_instr_cnt, 32'd8);
    op = 6'h00; funct = 6'h21;
    step(); step();
    chk("halt_hold_state", 32'(t_state), 32'd5);
    chk("halt_hold_cnt", t_instr_cnt, 32'd8);
    chk("halt_hold_we", {28'd0, t_ir_wr, t_pc_wr, t_reg_wr, t_mem_wr}, 32'd0);
    // Realign main instance to FETCH (addu just started two cycles ago)
    step(); step();
    chk("realign_state", 32'(state), 32'd0);
    chk("realign_cnt", instr_cnt, 32'd10);

    // Reset during MEM of sw aborts immediately
    op = 6'h2B; step(); step(); step();
    chk("swr_m_memwr", 32'(mem_wr), 32'd1);
    reset = 1'b0; #1;
    chk("swr_rst_memwr", 32'(mem_wr), 32'd0);
    chk("swr_rst_state", 32'(state), 32'd0);
    chk("swr_rst_cnt", instr_cnt, 32'd0);
    chk("swr_rst_trap", {28'd0, t_state, t_halt}, 32'd0);
    step();
    chk("swr_hold_irwr", 32'(ir_wr), 32'd0);
    chk("swr_hold_state", 32'(state), 32'd0);
    reset = 1'b1; #1;
    chk("swr_rel_irwr", 32'(ir_wr), 32'd1);
    step();
    chk("swr_rel_state", 32'(state), 32'd1);
    chk("swr_rel_cnt", instr_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
